// File: rtl/rhythm_pkg.sv
// Shared types and constants for the DFJK rhythm-game chart path.
package rhythm_pkg;

  localparam int unsigned CHART_ADDR_W     = 25;
  localparam int unsigned CHART_FIFO_DEPTH = 16;
  localparam logic [CHART_ADDR_W-1:0] CHART_BASE_ADDR = 25'h0100000;
  localparam logic [15:0] CHART_END = 16'hFFFF;

  typedef enum logic [1:0] {
    TAP        = 2'd0,
    HOLD_START = 2'd1,
    HOLD_END   = 2'd2,
    RSVD       = 2'd3
  } note_kind_e;

  typedef struct packed {
    logic [15:0] hit_time;
    logic [1:0]  lane;
    note_kind_e  kind;
  } note_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_REQ1  = 3'd2,
    ST_PUSH  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FLUSH = 3'd5
  } fetch_state_e;

  // Assemble a record from word0 (time) and the low nibble of word1.
  function automatic note_rec_t make_rec(input logic [15:0] w0, input logic [3:0] w1_lo);
    note_rec_t r;
    r.hit_time = w0;
    r.lane     = w1_lo[1:0];
    r.kind     = note_kind_e'(w1_lo[3:2]);
    return r;
  endfunction

endpackage

// File: rtl/chart_fetcher_if.sv
// SDRAM arbiter requester port: level rd/addr held until a one-cycle ac.
interface chart_fetcher_if
  import rhythm_pkg::*;
#(
  parameter int unsigned ADDR_W = CHART_ADDR_W
);

  logic              sdram_rd;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_Wait;
  logic              sdram_ac;
  logic [15:0]       sdram_data;

  modport master (
    output sdram_rd, sdram_addr,
    input  sdram_Wait, sdram_ac, sdram_data
  );

  modport slave (
    input  sdram_rd, sdram_addr,
    output sdram_Wait, sdram_ac, sdram_data
  );

endinterface

// File: rtl/chart_fetcher_fifo.sv
// First-word-fall-through FIFO of note records; flush has priority.
// Output data reads as zero while empty.
module chart_fifo
  import rhythm_pkg::*;
#(
  parameter int unsigned DEPTH = CHART_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  note_rec_t              wdata,
  output note_rec_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  note_rec_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer/count update; pop on empty is ignored, push accepted if a slot frees this cycle.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
      if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/chart_fetcher.sv
// Chart fetcher: streams 2-word note records from SDRAM into a prefetch FIFO
// until the end-of-chart sentinel. Optional stats outputs (rec_count,
// underrun) are built when CHART_FETCH_STATS_EN is defined.
module chart_fetcher
  import rhythm_pkg::*;
#(
  parameter int unsigned       ADDR_W     = CHART_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(CHART_BASE_ADDR),
  parameter int unsigned       FIFO_DEPTH = CHART_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  chart_fetcher_if.master        bus,
  output logic                   busy,
  output logic                   note_valid,
  input  logic                   note_rd,
  output logic [15:0]            note_time,
  output logic [1:0]             note_lane,
  output logic [1:0]             note_kind,
  output logic                   chart_done
`ifdef CHART_FETCH_STATS_EN
  ,
  output logic [15:0]            rec_count,
  output logic                   underrun
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       word0_q, word0_d;
  logic [3:0]        word1_q, word1_d;
  logic              done_q, done_d;
  logic              ac_hit_c, restart_c, push_c, flush_c;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  note_rec_t         head_rec;

  assign ac_hit_c = rd_q && bus.sdram_ac;

  // Restart: start while no request is in flight, or the ac that closes a discarded request.
  always_comb begin
    restart_c = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_PUSH: restart_c = start;
      ST_REQ0, ST_REQ1:          restart_c = start && (!rd_q || bus.sdram_ac);
      ST_FLUSH:                  restart_c = ac_hit_c;
      default:                   restart_c = 1'b0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      word0_q <= '0;
      word1_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (restart_c) begin
      state_d = ST_REQ0;
    end else begin
      unique case (state_q)
        ST_REQ0: begin
          if (start)         state_d = ST_FLUSH;
          else if (ac_hit_c) state_d = (bus.sdram_data == CHART_END) ? ST_DONE : ST_REQ1;
        end
        ST_REQ1: begin
          if (start)         state_d = ST_FLUSH;
          else if (ac_hit_c) state_d = ST_PUSH;
        end
        ST_PUSH: state_d = ST_REQ0;
        default: state_d = state_q;
      endcase
    end
  end

  // Request, address, word latch and FIFO control; a raised rd holds until ac.
  always_comb begin
    rd_d    = rd_q;
    addr_d  = addr_q;
    word0_d = word0_q;
    word1_d = word1_q;
    done_d  = done_q;
    push_c  = 1'b0;
    flush_c = 1'b0;
    if (restart_c) begin
      flush_c = 1'b1;
      rd_d    = 1'b0;
      addr_d  = BASE_ADDR;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_REQ0: begin
          if (!start) begin
            if (ac_hit_c) begin
              word0_d = bus.sdram_data;
              addr_d  = addr_q + ADDR_W'(1);
              rd_d    = 1'b0;
              done_d  = (bus.sdram_data == CHART_END);
            end else if (!rd_q && !bus.sdram_Wait && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
              rd_d = 1'b1;
            end
          end
        end
        ST_REQ1: begin
          if (!start) begin
            if (ac_hit_c) begin
              word1_d = bus.sdram_data[3:0];
              addr_d  = addr_q + ADDR_W'(1);
              rd_d    = 1'b0;
            end else if (!rd_q && !bus.sdram_Wait) begin
              rd_d = 1'b1;
            end
          end
        end
        ST_PUSH: push_c = !fifo_full;
        default: ;
      endcase
    end
  end

  chart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push_c),
    .pop   (note_rd),
    .flush (flush_c),
    .wdata (make_rec(word0_q, word1_q)),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.sdram_rd   = rd_q;
  assign bus.sdram_addr = addr_q;
  assign busy           = rd_q;
  assign chart_done     = done_q;
  assign note_valid     = !fifo_empty;
  assign note_time      = head_rec.hit_time;
  assign note_lane      = head_rec.lane;
  assign note_kind      = head_rec.kind;

`ifdef CHART_FETCH_STATS_EN
  logic [15:0] rec_count_q, rec_count_d;
  logic        underrun_q, underrun_d;

  // Saturating push counter and sticky empty-pop flag, both cleared by start.
  always_comb begin
    rec_count_d = rec_count_q;
    underrun_d  = underrun_q;
    if (start) begin
      rec_count_d = '0;
      underrun_d  = 1'b0;
    end else begin
      if (push_c && (rec_count_q != 16'hFFFF)) rec_count_d = rec_count_q + 16'd1;
      if (note_rd && fifo_empty)               underrun_d  = 1'b1;
    end
  end

  // Stats registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec_count_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      rec_count_q <= rec_count_d;
      underrun_q  <= underrun_d;
    end
  end

  assign rec_count = rec_count_q;
  assign underrun  = underrun_q;
`endif

endmodule

// File: tb/tb_chart_fetcher.sv
// Directed bench for chart_fetcher with a behavioural SDRAM arbiter model.
module tb_chart_fetcher;

  localparam logic [24:0] BASE = 25'h0100000;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] exp_time;
    logic [1:0]  exp_lane;
    logic [1:0]  exp_kind;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        note_rd;
  logic        busy, note_valid, chart_done;
  logic [15:0] note_time;
  logic [1:0]  note_lane, note_kind;
`ifdef CHART_FETCH_STATS_EN
  logic [15:0] rec_count;
  logic        underrun;
`endif

  int          total = 0;
  int          bad   = 0;
  vec_t        tbl [6];
  logic [15:0] mem [128];
  int          ack_cnt  = 0;
  int          ack_base = 0;
  int          resp_lat = 0;
  bit          resp_en  = 1'b1;
  int          inj_req  = 0;

  chart_fetcher_if #(.ADDR_W(25)) bus ();

  chart_fetcher dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .note_valid (note_valid),
    .note_rd    (note_rd),
    .note_time  (note_time),
    .note_lane  (note_lane),
    .note_kind  (note_kind),
    .chart_done (chart_done)
`ifdef CHART_FETCH_STATS_EN
    ,
    .rec_count  (rec_count),
    .underrun   (underrun)
`endif
  );

  always #5 clk = ~clk;

  // Arbiter model: acks a raised rd after resp_lat cycles, or injects a stray ac on request.
  initial begin : responder
    logic [24:0] off;
    int          lat_cnt;
    int          inj_done;
    lat_cnt = 0;
    inj_done = 0;
    bus.sdram_ac   = 1'b0;
    bus.sdram_data = '0;
    forever begin
      @(negedge clk);
      if (bus.sdram_ac) begin
        bus.sdram_ac = 1'b0;
        lat_cnt = 0;
      end else if (inj_req != inj_done) begin
        bus.sdram_ac   = 1'b1;
        bus.sdram_data = 16'h1234;
        inj_done = inj_req;
      end else if (resp_en && bus.sdram_rd) begin
        if (lat_cnt >= resp_lat) begin
          off = bus.sdram_addr - BASE;
          bus.sdram_data = (off < 25'd128) ? mem[off[6:0]] : 16'hFFFF;
          bus.sdram_ac   = 1'b1;
          ack_cnt++;
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !chart_done; i++) step();
    chk("done_seen", 32'(chart_done), 32'd1);
  endtask

  task automatic wait_rd(input int budget);
    for (int i = 0; i < budget && !bus.sdram_rd; i++) step();
    chk("rd_seen", 32'(bus.sdram_rd), 32'd1);
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && ack_cnt < target; i++) step();
    chk("acks_reached", 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic pop_chk(input string nm, input logic [15:0] t, input logic [1:0] l,
                         input logic [1:0] k);
    for (int i = 0; i < 60 && !note_valid; i++) step();
    chk(nm, {12'd0, note_valid, note_time, note_lane, note_kind}, {12'd0, 1'b1, t, l, k});
    note_rd = 1'b1;
    step();
    note_rd = 1'b0;
  endtask

  task automatic load_tbl(input int n);
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      mem[2*i]   = tbl[i].w0;
      mem[2*i+1] = tbl[i].w1;
    end
  endtask

  task automatic load_long();
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
    for (int i = 0; i < 40; i++) begin
      mem[2*i]   = 16'(10 * (i + 1));
      mem[2*i+1] = {12'(i * 7 + 3), 2'((i / 4) % 3), 2'(i % 4)};
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    tbl[0] = '{16'h0064, 16'h0001, 16'd100,   2'd1, 2'd0};
    tbl[1] = '{16'h00C8, 16'h0006, 16'd200,   2'd2, 2'd1};
    tbl[2] = '{16'h0000, 16'hFFFB, 16'h0000,  2'd3, 2'd2};
    tbl[3] = '{16'hFFFE, 16'h123C, 16'hFFFE,  2'd0, 2'd3};
    tbl[4] = '{16'h1388, 16'h0009, 16'd5000,  2'd1, 2'd2};
    tbl[5] = '{16'h7530, 16'hABC7, 16'd30000, 2'd3, 2'd1};

    reset_n = 1'b0;
    start   = 1'b0;
    note_rd = 1'b0;
    bus.sdram_Wait = 1'b0;
    load_tbl(6);
    step();
    step();

    // Reset values.
    chk("rst_rd",    32'(bus.sdram_rd), 32'd0);
    chk("rst_addr",  32'(bus.sdram_addr), 32'(BASE));
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_done",  32'(chart_done), 32'd0);
    chk("rst_rec",   {12'd0, note_time, note_lane, note_kind}, 32'd0);
    reset_n = 1'b1;
    step();

    // Table-driven chart: fetch all, then pop and compare every record.
    ack_base = ack_cnt;
    pulse_start();
    wait_done(400);
    chk("tbl_acks", 32'(ack_cnt - ack_base), 32'd13);
    chk("tbl_addr", 32'(bus.sdram_addr), 32'(BASE + 25'd13));
    chk("tbl_rd_done", 32'(bus.sdram_rd), 32'd0);
    for (int i = 0; i < 6; i++) pop_chk("tbl_rec", tbl[i].exp_time, tbl[i].exp_lane, tbl[i].exp_kind);
    chk("tbl_empty", 32'(note_valid), 32'd0);

    // Wait blocks raising rd; once raised, Wait does not disturb rd/addr.
    bus.sdram_Wait = 1'b1;
    resp_en = 1'b0;
    ack_base = ack_cnt;
    pulse_start();
    chk("wait_done_clr", 32'(chart_done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("wait_rd_low", 32'(bus.sdram_rd), 32'd0);
      step();
    end
    bus.sdram_Wait = 1'b0;
    step();
    chk("wait_rd_rise", 32'(bus.sdram_rd), 32'd1);
    chk("wait_addr", 32'(bus.sdram_addr), 32'(BASE));
    bus.sdram_Wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_hold", {7'd0, bus.sdram_rd, bus.sdram_addr}, {7'd0, 1'b1, BASE});
    end
    resp_en = 1'b1;
    wait_acks(ack_base + 1, 10);
    step();
    step();
    step();
    chk("wait_blocks_req1", 32'(bus.sdram_rd), 32'd0);
    bus.sdram_Wait = 1'b0;
    wait_done(400);
    chk("wait_acks", 32'(ack_cnt - ack_base), 32'd13);

    // Long chart with no pops: stall on a full FIFO, then resume one record at a time.
    load_long();
    ack_base = ack_cnt;
    pulse_start();
    for (int i = 0; i < 200; i++) step();
    chk("full_acks",  32'(ack_cnt - ack_base), 32'd32);
    chk("full_rd",    32'(bus.sdram_rd), 32'd0);
    chk("full_busy",  32'(busy), 32'd0);
    chk("full_addr",  32'(bus.sdram_addr), 32'(BASE + 25'd32));
    pop_chk("long_rec", 16'd10, 2'd0, 2'd0);
    wait_rd(10);
    chk("resume_addr", 32'(bus.sdram_addr), 32'(BASE + 25'd32));
    wait_acks(ack_base + 34, 40);
    step();
    pop_chk("long_rec", 16'd20, 2'd1, 2'd0);
    for (int i = 0; i < 100; i++) step();
    chk("pushpop_acks", 32'(ack_cnt - ack_base), 32'd36);
    chk("pushpop_rd",   32'(bus.sdram_rd), 32'd0);
    for (int i = 2; i < 40; i++) pop_chk("long_rec", 16'(10 * (i + 1)), 2'(i % 4), 2'((i / 4) % 3));
    wait_done(200);
    chk("long_acks", 32'(ack_cnt - ack_base), 32'd81);
    chk("long_empty", 32'(note_valid), 32'd0);

    // start while a request is outstanding: its data is discarded and fetch restarts.
    load_tbl(6);
    resp_lat = 5;
    ack_base = ack_cnt;
    pulse_start();
    wait_acks(ack_base + 3, 100);
    step();
    wait_rd(20);
    chk("flush_pre_addr",  32'(bus.sdram_addr), 32'(BASE + 25'd3));
    chk("flush_pre_valid", 32'(note_valid), 32'd1);
    pulse_start();
    chk("flush_rd_kept", 32'(bus.sdram_rd), 32'd1);
    wait_acks(ack_base + 4, 20);
    resp_lat = 0;
    step();
    chk("flush_valid", 32'(note_valid), 32'd0);
    chk("flush_rd",    32'(bus.sdram_rd), 32'd0);
    chk("flush_addr",  32'(bus.sdram_addr), 32'(BASE));
    step();
    chk("flush_req", {7'd0, bus.sdram_rd, bus.sdram_addr}, {7'd0, 1'b1, BASE});
    wait_done(400);
    chk("flush_acks", 32'(ack_cnt - ack_base), 32'd17);
    pop_chk("flush_first", 16'd100, 2'd1, 2'd0);

    // Asynchronous reset mid-request with 3 records buffered; a late ac is ignored.
    resp_lat = 2;
    ack_base = ack_cnt;
    pulse_start();
    wait_acks(ack_base + 6, 100);
    step();
    wait_rd(20);
    chk("rst_pre_valid", 32'(note_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_rd",    32'(bus.sdram_rd), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_valid", 32'(note_valid), 32'd0);
    chk("arst_rec",   {12'd0, note_time, note_lane, note_kind}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    inj_req++;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("late_ac_idle", {5'd0, bus.sdram_rd, note_valid, chart_done, bus.sdram_addr},
          {5'd0, 1'b0, 1'b0, 1'b0, BASE});
      step();
    end

`ifdef CHART_FETCH_STATS_EN
    // Stats: sticky underrun, record count, both cleared by start.
    resp_lat = 0;
    chk("st_underrun_rst", 32'(underrun), 32'd0);
    note_rd = 1'b1;
    step();
    note_rd = 1'b0;
    chk("st_underrun_set", 32'(underrun), 32'd1);
    load_tbl(3);
    pulse_start();
    chk("st_underrun_clr", 32'(underrun), 32'd0);
    chk("st_count_clr",    32'(rec_count), 32'd0);
    wait_done(200);
    chk("st_count3", 32'(rec_count), 32'd3);
    pulse_start();
    chk("st_count_start", 32'(rec_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
